// File: rtl/systolic_drain_unit_pkg.sv
// Shared constants and FSM state type for the systolic drain unit.
package systolic_drain_unit_pkg;

  localparam int ARRAY_DIM      = 4;
  localparam int WARP_SIZE      = 8;
  localparam int NUM_PE         = ARRAY_DIM * ARRAY_DIM;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    BEAT0,
    BEAT1,
    DONE
  } drain_state_t;

endpackage

// File: rtl/systolic_drain_unit_if.sv
// Writeback handshake bus from the drain unit to the warp register file.
interface systolic_drain_unit_if
  import systolic_drain_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                                 wb_valid;
  logic                                 wb_ready;
  logic                                 wb_beat;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] wb_data;

  modport master (
    output wb_valid,
    output wb_beat,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_beat,
    input  wb_data,
    output wb_ready
  );

endinterface

// File: rtl/systolic_drain_unit_acc_narrow.sv
// Combinational accumulator narrowing: arithmetic shift, then saturate when
// DRAIN_SATURATE_EN is defined, otherwise truncate (wrap) to DATA_WIDTH.
module acc_narrow #(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_SHIFT = 0
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic        [DATA_WIDTH-1:0] result
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] s);
    if (s > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (s < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return DATA_WIDTH'(s);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] truncate(input logic signed [ACC_WIDTH-1:0] s);
    return DATA_WIDTH'(s);
  endfunction

  logic signed [ACC_WIDTH-1:0] shifted;

  assign shifted = acc >>> FRAC_SHIFT;

`ifdef DRAIN_SATURATE_EN
  assign result = saturate(shifted);
`else
  assign result = truncate(shifted);
`endif

endmodule

// File: rtl/systolic_drain_unit.sv
// Drains the 4x4 PE accumulator array into the warp register file as two
// 8-lane beats. Narrowing mode selected by the DRAIN_SATURATE_EN macro.
module systolic_drain_unit
  import systolic_drain_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              pause,
  input  logic                              matmul_done,
  input  logic [NUM_PE-1:0][ACC_WIDTH-1:0]  acc_in,
  output logic                              acc_clear,
  systolic_drain_unit_if.master             wb,
  output logic                              drain_busy,
  output logic                              drain_done,
  output logic                              drain_overrun
);

  drain_state_t                           state;
  logic                                   done_q;
  logic                                   start;
  logic                                   vld_p1;
  logic                                   beat_q;
  logic [NUM_PE-1:0][ACC_WIDTH-1:0]       snap_p0;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]   lane_data;

  assign start       = matmul_done & ~done_q;
  assign wb.wb_valid = vld_p1 & ~pause;
  assign wb.wb_beat  = beat_q;
  assign wb.wb_data  = lane_data;

  // Control FSM; pause freezes every transition but not edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      done_q        <= 1'b0;
      acc_clear     <= 1'b0;
      vld_p1        <= 1'b0;
      beat_q        <= 1'b0;
      drain_busy    <= 1'b0;
      drain_done    <= 1'b0;
      drain_overrun <= 1'b0;
    end else begin
      done_q     <= matmul_done;
      acc_clear  <= 1'b0;
      drain_done <= 1'b0;
      if (start && state != IDLE) drain_overrun <= 1'b1;
      if (!pause) begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= CAPTURE;
              acc_clear  <= 1'b1;
              drain_busy <= 1'b1;
            end
          end
          CAPTURE: begin
            state  <= BEAT0;
            vld_p1 <= 1'b1;
            beat_q <= 1'b0;
          end
          BEAT0: begin
            if (wb.wb_ready) begin
              state  <= BEAT1;
              beat_q <= 1'b1;
            end
          end
          BEAT1: begin
            if (wb.wb_ready) begin
              state      <= DONE;
              vld_p1     <= 1'b0;
              beat_q     <= 1'b0;
              drain_done <= 1'b1;
            end
          end
          DONE: begin
            state      <= IDLE;
            drain_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Snapshot is taken on the single acc_clear cycle, before the PEs zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       snap_p0 <= '0;
    else if (acc_clear) snap_p0 <= acc_in;
  end

  // Lane i of beat b carries PE index b*8 + i.
  for (genvar lane = 0; lane < WARP_SIZE; lane++) begin : g_lane
    logic [ACC_WIDTH-1:0] sel_p1;

    assign sel_p1 = beat_q ? snap_p0[lane + WARP_SIZE] : snap_p0[lane];

    acc_narrow #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_SHIFT (FRAC_SHIFT)
    ) u_narrow (
      .acc    (sel_p1),
      .result (lane_data[lane])
    );
  end

endmodule
